// File: rtl/wb_pkg.sv
// Shared definitions for the Wishbone classic-cycle master.
//   - wb_state_e   : master FSM state encoding (code 2'd3 is unused and
//                    recovers to IDLE inside the FSM).
//   - WB_*_DEFAULT : default data/address widths and timeout depth.
//   - wb_cnt_width : width of the timeout down-counter for a given depth.
package wb_pkg;

    localparam int unsigned WB_DW_DEFAULT      = 8;
    localparam int unsigned WB_AW_DEFAULT      = 16;
    localparam int unsigned WB_TIMEOUT_DEFAULT = 15;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_DONE = 2'd2
    } wb_state_e;

    // Enough bits to hold the value `timeout`, never less than one bit.
    function automatic int unsigned wb_cnt_width(input int unsigned timeout);
        int unsigned w;
        w = $clog2(timeout + 1);
        return (w == 0) ? 1 : w;
    endfunction

endpackage

// File: rtl/wb_timeout_counter.sv
// Bus-cycle watchdog for the Wishbone master.
//   clk_i, rst_i : clock, asynchronous active-high reset
//   load         : preload the counter with TIMEOUT (cycle start)
//   en           : count down by one (stops at zero, never wraps)
//   expired      : counter has reached zero; constant 0 when TIMEOUT == 0
module wb_timeout_counter
    import wb_pkg::*;
#(
    parameter int unsigned TIMEOUT = WB_TIMEOUT_DEFAULT
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic load,
    input  logic en,
    output logic expired
);

    localparam int unsigned    CW       = wb_cnt_width(TIMEOUT);
    localparam logic [CW-1:0]  LOAD_VAL = CW'(TIMEOUT);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = LOAD_VAL;
        end else if (en && (cnt_q != '0)) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // A zero depth means "wait forever", so the comparison folds away.
    assign expired = (TIMEOUT != 0) && (cnt_q == '0);

endmodule

// File: rtl/wb_master_ctrl.sv
// Registered Wishbone classic-cycle master bridging a CPU memory port.
// Captures one CPU request in IDLE, runs a single STB/CYC cycle in BUS,
// spends one DONE cycle after termination, then returns to IDLE.
//   clk_i, rst_i     : clock, asynchronous active-high reset
//   ack_i, err_i     : slave acknowledge / error termination
//   dat_i            : slave read data
//   dat_o, adr_o     : registered write data / address
//   we_o, stb_o      : registered write enable / strobe
//   cyc_o            : cycle, identical to stb_o
//   cpu_rd, cpu_wr   : CPU read / write request (both set => write)
//   cpu_dir          : CPU address
//   cpu_data_i       : CPU write data
//   enable_wishbone  : address decode hit qualifying cpu_rd / cpu_wr
//   cpu_data_o       : last successfully read data, registered
//   cpu_wait         : combinational CPU stall
//   cpu_err          : one-cycle pulse on error or timeout termination
module wb_master_ctrl
    import wb_pkg::*;
#(
    parameter int unsigned DW      = WB_DW_DEFAULT,
    parameter int unsigned AW      = WB_AW_DEFAULT,
    parameter int unsigned TIMEOUT = WB_TIMEOUT_DEFAULT
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          ack_i,
    input  logic          err_i,
    input  logic [DW-1:0] dat_i,
    output logic [DW-1:0] dat_o,
    output logic [AW-1:0] adr_o,
    output logic          we_o,
    output logic          stb_o,
    output logic          cyc_o,
    input  logic          cpu_rd,
    input  logic          cpu_wr,
    input  logic [AW-1:0] cpu_dir,
    input  logic [DW-1:0] cpu_data_i,
    input  logic          enable_wishbone,
    output logic [DW-1:0] cpu_data_o,
    output logic          cpu_wait,
    output logic          cpu_err
);

    wb_state_e     state_q, state_d;
    logic [AW-1:0] adr_q, adr_d;
    logic [DW-1:0] dat_q, dat_d;
    logic          we_q, we_d;
    logic          stb_q, stb_d;
    logic [DW-1:0] cpu_data_q, cpu_data_d;
    logic          cpu_err_q, cpu_err_d;

    logic req;
    logic cnt_load;
    logic cnt_en;
    logic expired;

    assign req = enable_wishbone & (cpu_rd | cpu_wr);

    wb_timeout_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .load    (cnt_load),
        .en      (cnt_en),
        .expired (expired)
    );

    always_comb begin
        state_d    = state_q;
        adr_d      = adr_q;
        dat_d      = dat_q;
        we_d       = we_q;
        stb_d      = stb_q;
        cpu_data_d = cpu_data_q;
        cpu_err_d  = 1'b0;
        cnt_load   = 1'b0;
        cnt_en     = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (req) begin
                    adr_d    = cpu_dir;
                    dat_d    = cpu_data_i;
                    we_d     = cpu_wr;
                    stb_d    = 1'b1;
                    cnt_load = 1'b1;
                    state_d  = ST_BUS;
                end
            end
            ST_BUS: begin
                // err beats ack beats timeout; ack on the expiry cycle succeeds.
                if (err_i) begin
                    stb_d     = 1'b0;
                    cpu_err_d = 1'b1;
                    state_d   = ST_DONE;
                end else if (ack_i) begin
                    stb_d   = 1'b0;
                    if (!we_q) begin
                        cpu_data_d = dat_i;
                    end
                    state_d = ST_DONE;
                end else if (expired) begin
                    stb_d     = 1'b0;
                    cpu_err_d = 1'b1;
                    state_d   = ST_DONE;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                stb_d   = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            adr_q      <= '0;
            dat_q      <= '0;
            we_q       <= 1'b0;
            stb_q      <= 1'b0;
            cpu_data_q <= '0;
            cpu_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            adr_q      <= adr_d;
            dat_q      <= dat_d;
            we_q       <= we_d;
            stb_q      <= stb_d;
            cpu_data_q <= cpu_data_d;
            cpu_err_q  <= cpu_err_d;
        end
    end

    // Reset gates the stall so a CPU still holding its request during reset
    // is released immediately rather than after the reset is removed.
    always_comb begin
        cpu_wait = ~rst_i & (((state_q == ST_IDLE) & req) | (state_q == ST_BUS));
    end

    assign dat_o      = dat_q;
    assign adr_o      = adr_q;
    assign we_o       = we_q;
    assign stb_o      = stb_q;
    assign cyc_o      = stb_q;
    assign cpu_data_o = cpu_data_q;
    assign cpu_err    = cpu_err_q;

endmodule

// File: tb/tb_wb_master_ctrl.sv
// Scoreboard bench for wb_master_ctrl. The driver issues CPU requests and
// plays the slave; for each request it pushes the expected bus cycle
// (address, data, direction, strobe length, error, read-back value) into a
// queue. A monitor watching stb_o pops and compares when a cycle ends.
module tb_wb_master_ctrl;

    localparam int unsigned TO = 15;

    typedef struct {
        logic        we;
        logic [15:0] adr;
        logic [7:0]  dat;
        int unsigned cycles;
        logic        err;
        logic [7:0]  rdata;
    } exp_t;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        ack_i = 1'b0;
    logic        err_i = 1'b0;
    logic [7:0]  dat_i = '0;
    logic [7:0]  dat_o;
    logic [15:0] adr_o;
    logic        we_o;
    logic        stb_o;
    logic        cyc_o;
    logic        cpu_rd = 1'b0;
    logic        cpu_wr = 1'b0;
    logic [15:0] cpu_dir = '0;
    logic [7:0]  cpu_data_i = '0;
    logic        enable_wishbone = 1'b0;
    logic [7:0]  cpu_data_o;
    logic        cpu_wait;
    logic        cpu_err;

    int unsigned total = 0;
    int unsigned bad   = 0;
    exp_t        sb[$];
    logic [7:0]  model_rdata = '0;

    wb_master_ctrl #(
        .DW      (8),
        .AW      (16),
        .TIMEOUT (TO)
    ) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .ack_i           (ack_i),
        .err_i           (err_i),
        .dat_i           (dat_i),
        .dat_o           (dat_o),
        .adr_o           (adr_o),
        .we_o            (we_o),
        .stb_o           (stb_o),
        .cyc_o           (cyc_o),
        .cpu_rd          (cpu_rd),
        .cpu_wr          (cpu_wr),
        .cpu_dir         (cpu_dir),
        .cpu_data_i      (cpu_data_i),
        .enable_wishbone (enable_wishbone),
        .cpu_data_o      (cpu_data_o),
        .cpu_wait        (cpu_wait),
        .cpu_err         (cpu_err)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: samples on the falling edge, away from the active edge.
    logic        prev_stb = 1'b0;
    int unsigned stb_len  = 0;
    logic [15:0] cap_adr;
    logic [7:0]  cap_dat;
    logic        cap_we;

    always @(negedge clk_i) begin
        exp_t e;
        if (rst_i) begin
            prev_stb = 1'b0;
            stb_len  = 0;
        end else begin
            chk("cyc_eq_stb", {31'd0, cyc_o}, {31'd0, stb_o});
            if (stb_o) begin
                if (!prev_stb) begin
                    cap_adr = adr_o;
                    cap_dat = dat_o;
                    cap_we  = we_o;
                    stb_len = 1;
                end else begin
                    stb_len++;
                end
                chk("wait_in_bus", {31'd0, cpu_wait}, 32'd1);
            end else if (prev_stb) begin
                if (sb.size() == 0) begin
                    chk("unexpected_cycle", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("adr", {16'd0, cap_adr}, {16'd0, e.adr});
                    chk("we", {31'd0, cap_we}, {31'd0, e.we});
                    chk("dat_o", {24'd0, cap_dat}, {24'd0, e.dat});
                    chk("stb_len", stb_len, e.cycles);
                    chk("cpu_err", {31'd0, cpu_err}, {31'd0, e.err});
                    chk("cpu_data_o", {24'd0, cpu_data_o}, {24'd0, e.rdata});
                    chk("wait_in_done", {31'd0, cpu_wait}, 32'd0);
                end
            end else begin
                chk("err_idle", {31'd0, cpu_err}, 32'd0);
            end
            prev_stb = stb_o;
        end
    end

    // mode: 0 ack at cycle k, 1 err at k, 2 err+ack at k, 3 no response.
    task automatic run_txn(input logic rd, input logic wr, input logic [15:0] a,
                           input logic [7:0] d, input logic [7:0] rdat,
                           input int unsigned mode, input int unsigned k);
        exp_t e;
        int unsigned n;
        e.we  = wr;
        e.adr = a;
        e.dat = d;
        if (mode == 3) begin
            n     = TO + 1;
            e.err = 1'b1;
        end else begin
            n     = k;
            e.err = (mode != 0);
        end
        e.cycles = n;
        if (mode == 0 && !wr) model_rdata = rdat;
        e.rdata = model_rdata;
        sb.push_back(e);

        @(negedge clk_i);
        cpu_rd = rd; cpu_wr = wr; cpu_dir = a; cpu_data_i = d; enable_wishbone = 1'b1;
        #1 chk("wait_on_req", {31'd0, cpu_wait}, 32'd1);
        @(posedge clk_i);
        for (int unsigned c = 1; c <= n; c++) begin
            @(negedge clk_i);
            // CPU-side noise during the bus cycle must be ignored.
            cpu_rd          = 1'($urandom);
            cpu_wr          = 1'($urandom);
            cpu_dir         = 16'($urandom);
            cpu_data_i      = 8'($urandom);
            enable_wishbone = 1'($urandom);
            dat_i = (c == k) ? rdat : 8'($urandom);
            ack_i = (c == k) && (mode == 0 || mode == 2);
            err_i = (c == k) && (mode == 1 || mode == 2);
            @(posedge clk_i);
        end
        @(negedge clk_i);
        ack_i = 1'b0; err_i = 1'b0;
        cpu_rd = 1'b0; cpu_wr = 1'b0; enable_wishbone = 1'b0;
    endtask

    initial begin
        int unsigned mode, k;
        logic rd, wr;

        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        chk("rst_stb", {31'd0, stb_o}, 32'd0);
        chk("rst_wait", {31'd0, cpu_wait}, 32'd0);
        chk("rst_data", {24'd0, cpu_data_o}, 32'd0);
        chk("rst_adr", {16'd0, adr_o}, 32'd0);
        #1 rst_i = 1'b0;

        // Directed cases
        run_txn(1'b1, 1'b0, 16'h1234, 8'h00, 8'hA5, 0, 3);
        run_txn(1'b0, 1'b1, 16'h8000, 8'h3C, 8'h77, 0, 1);
        run_txn(1'b1, 1'b0, 16'h00F0, 8'h11, 8'h99, 3, 0);
        run_txn(1'b1, 1'b0, 16'h4242, 8'h22, 8'h5A, 2, 2);
        run_txn(1'b1, 1'b0, 16'h0101, 8'h33, 8'hC3, 0, TO + 1);
        run_txn(1'b1, 1'b1, 16'hBEEF, 8'h44, 8'h66, 1, TO + 1);

        // Randomized cases
        for (int i = 0; i < 40; i++) begin
            mode = $urandom_range(0, 3);
            k    = $urandom_range(1, TO + 1);
            rd   = 1'($urandom);
            wr   = 1'($urandom);
            if (!rd && !wr) rd = 1'b1;
            run_txn(rd, wr, 16'($urandom), 8'($urandom), 8'($urandom), mode, k);
        end

        // Request without address decode hit: no cycle, no stall.
        @(negedge clk_i);
        enable_wishbone = 1'b0; cpu_rd = 1'b1; cpu_dir = 16'h5555;
        for (int i = 0; i < 3; i++) begin
            #1 chk("nodec_wait", {31'd0, cpu_wait}, 32'd0);
            @(posedge clk_i);
            #1 chk("nodec_stb", {31'd0, stb_o}, 32'd0);
            @(negedge clk_i);
        end
        cpu_rd = 1'b0;

        // Reset in the middle of a bus cycle, request still held.
        @(negedge clk_i);
        cpu_rd = 1'b1; cpu_dir = 16'h0F0F; enable_wishbone = 1'b1;
        @(posedge clk_i);
        @(posedge clk_i);
        #2 rst_i = 1'b1;
        #1;
        chk("rst_mid_stb", {31'd0, stb_o}, 32'd0);
        chk("rst_mid_cyc", {31'd0, cyc_o}, 32'd0);
        chk("rst_mid_wait", {31'd0, cpu_wait}, 32'd0);
        chk("rst_mid_data", {24'd0, cpu_data_o}, 32'd0);
        @(negedge clk_i);
        cpu_rd = 1'b0; enable_wishbone = 1'b0;
        model_rdata = '0;
        #1 rst_i = 1'b0;

        run_txn(1'b1, 1'b0, 16'h2468, 8'h00, 8'hE7, 0, 2);
        run_txn(1'b0, 1'b1, 16'h1357, 8'hD2, 8'h00, 0, 4);

        repeat (4) @(posedge clk_i);
        #1 chk("sb_drained", sb.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
